// File: rtl/spi_slave_top.sv
// SPI responder: deserialises a (2*DATA_WIDTH+1)-bit command frame into a register write or read
// and returns read data on miso in a second chip-select window requested with s_read_vld.
module spi_slave_top #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int RD_TIMEOUT  = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  cs_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  s_read_vld,
  output logic                  reg_wr_en,
  output logic                  reg_rd_en,
  output logic [DATA_WIDTH-1:0] reg_addr,
  output logic [DATA_WIDTH-1:0] reg_wdata,
  input  logic [DATA_WIDTH-1:0] reg_rdata,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int FRAME_BITS = 2*DATA_WIDTH + 1;
  localparam int CNT_W      = $clog2(2*DATA_WIDTH + 2);
  localparam int WAIT_W     = $clog2(RD_TIMEOUT + 1);

  localparam logic [CNT_W-1:0]  CNT_FRAME     = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0]  CNT_LAST_TX   = CNT_W'(DATA_WIDTH - 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT_M1 = WAIT_W'(RD_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CMD_RX  = 3'd1,
    EXEC    = 3'd2,
    RD_CAP  = 3'd3,
    RD_WAIT = 3'd4,
    RD_TX   = 3'd5
  } state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sclk_prev_q, cs_prev_q;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_rise_s, sclk_fall_s, cs_rise_s, cs_fall_s;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic                   overrun_q, overrun_d;
  logic [FRAME_BITS-1:0]  cmd_sr_q, cmd_sr_d;
  logic [DATA_WIDTH-1:0]  tx_sr_q, tx_sr_d;
  logic [WAIT_W-1:0]      wait_cnt_q, wait_cnt_d;
  logic                   miso_q, miso_d;
  logic                   s_read_vld_q, s_read_vld_d;
  logic                   reg_wr_en_q, reg_wr_en_d;
  logic                   reg_rd_en_q, reg_rd_en_d;
  logic [DATA_WIDTH-1:0]  reg_addr_q, reg_addr_d;
  logic [DATA_WIDTH-1:0]  reg_wdata_q, reg_wdata_d;
  logic                   frame_err_q, frame_err_d;
  logic                   busy_q, busy_d;

  // Input synchronisers; cleared to 0 so a cs_n already low at reset release never looks like a fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
      cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
    end
  end

  assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s        = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise_s = sclk_s & ~sclk_prev_q;
  assign sclk_fall_s = ~sclk_s & sclk_prev_q;
  assign cs_rise_s   = cs_s & ~cs_prev_q;
  assign cs_fall_s   = ~cs_s & cs_prev_q;

  // Next-state and next-output logic; strobes are set one cycle early so they coincide with their state.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    overrun_d    = overrun_q;
    cmd_sr_d     = cmd_sr_q;
    tx_sr_d      = tx_sr_q;
    wait_cnt_d   = wait_cnt_q;
    miso_d       = 1'b0;
    s_read_vld_d = 1'b0;
    reg_wr_en_d  = 1'b0;
    reg_rd_en_d  = 1'b0;
    reg_addr_d   = reg_addr_q;
    reg_wdata_d  = reg_wdata_q;
    frame_err_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (cs_fall_s) begin
          state_d   = CMD_RX;
          bit_cnt_d = '0;
          overrun_d = 1'b0;
          cmd_sr_d  = '0;
        end else begin
          state_d = IDLE;
        end
      end
      CMD_RX: begin
        if (cs_rise_s) begin
          if ((bit_cnt_q == CNT_FRAME) && !overrun_q) begin
            state_d     = EXEC;
            reg_addr_d  = cmd_sr_q[DATA_WIDTH:1];
            reg_wdata_d = cmd_sr_q[2*DATA_WIDTH:DATA_WIDTH+1];
            if (cmd_sr_q[0]) begin
              reg_wr_en_d = 1'b1;
            end else begin
              reg_rd_en_d = 1'b1;
            end
          end else begin
            state_d     = IDLE;
            frame_err_d = 1'b1;
          end
        end else if (sclk_rise_s) begin
          // LSB arrives first, so shifting in at the top leaves bit 0 at index 0 after a full frame.
          if (bit_cnt_q == CNT_FRAME) begin
            overrun_d = 1'b1;
          end else begin
            cmd_sr_d  = {mosi_s, cmd_sr_q[FRAME_BITS-1:1]};
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end else begin
          state_d = CMD_RX;
        end
      end
      EXEC: begin
        if (cmd_sr_q[0]) begin
          state_d = IDLE;
        end else begin
          state_d      = RD_CAP;
          s_read_vld_d = 1'b1;
        end
      end
      RD_CAP: begin
        tx_sr_d    = reg_rdata;
        wait_cnt_d = WAIT_W'(1);
        state_d    = RD_WAIT;
      end
      RD_WAIT: begin
        if (cs_fall_s) begin
          state_d   = RD_TX;
          miso_d    = tx_sr_q[0];
          bit_cnt_d = '0;
        end else if (wait_cnt_q >= WAIT_LIMIT_M1) begin
          state_d     = IDLE;
          frame_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      RD_TX: begin
        if (cs_rise_s) begin
          state_d = IDLE;
        end else if (sclk_fall_s && (bit_cnt_q < CNT_LAST_TX)) begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          tx_sr_d   = {1'b0, tx_sr_q[DATA_WIDTH-1:1]};
          miso_d    = tx_sr_q[1];
        end else begin
          miso_d = miso_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State, counters, shift registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      overrun_q    <= 1'b0;
      cmd_sr_q     <= '0;
      tx_sr_q      <= '0;
      wait_cnt_q   <= '0;
      miso_q       <= 1'b0;
      s_read_vld_q <= 1'b0;
      reg_wr_en_q  <= 1'b0;
      reg_rd_en_q  <= 1'b0;
      reg_addr_q   <= '0;
      reg_wdata_q  <= '0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      overrun_q    <= overrun_d;
      cmd_sr_q     <= cmd_sr_d;
      tx_sr_q      <= tx_sr_d;
      wait_cnt_q   <= wait_cnt_d;
      miso_q       <= miso_d;
      s_read_vld_q <= s_read_vld_d;
      reg_wr_en_q  <= reg_wr_en_d;
      reg_rd_en_q  <= reg_rd_en_d;
      reg_addr_q   <= reg_addr_d;
      reg_wdata_q  <= reg_wdata_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
    end
  end

  assign miso       = miso_q;
  assign s_read_vld = s_read_vld_q;
  assign reg_wr_en  = reg_wr_en_q;
  assign reg_rd_en  = reg_rd_en_q;
  assign reg_addr   = reg_addr_q;
  assign reg_wdata  = reg_wdata_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;

endmodule
